fsm_add_subt_param: RTL and testbench
=====================================

# fsm_add_subt_param

Parametrised control FSM for the floating-point add/subtract datapath. Sequences operand load, zero check, exponent difference, significand alignment, add/subtract, overflow normalisation, rounding and final-result load. Adds a configurable barrel-shifter settle delay (single/double precision), a normalisation-pass watchdog, mid-operation abort and a busy flag. Sits beside the add/subtract datapath and drives its register enables and mux selects.

## Interface
- W, 32, datapath precision (32 or 64); sets only the SHIFT_WAIT default
- SHIFT_WAIT, (W==64)?1:0, settle cycles between an exponent load and the following barrel-shifter load (0..7)
- MAX_NORM, 2, normalisation passes allowed before the watchdog fires (1..7)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- beg_fsm  in  1  start request, sampled in IDLE
- rst_fsm  in  1  acknowledge in DONE; abort in any other non-IDLE state
- zero_flag_i, real_op_i, norm_iteration_i, add_overflow_i, round_i  in  1 each  datapath status
- load_1_o..load_8_o  out  1 each  register enables (operands, oper-start, exponent, shifter, adder, LZA, final, exponent-aux)
- A_S_op_o  out  1  exponent op (1 = add/default, 0 = subtract)
- left_right_o  out  1  shift direction (0 right, 1 left)
- bit_shift_o  out  1  shift fill bit
- ctrl_a_o, ctrl_c_o, ctrl_d_o  out  1 each  mux selects
- ctrl_b_o  out  2  exponent B / shift-amount select
- ctrl_b_load_o  out  1  ctrl_b register enable
- rst_int  out  1  internal datapath reset
- ready  out  1  result valid
- busy  out  1  high in every state except IDLE and DONE
- norm_err  out  1  watchdog fired for the current operation

## Operation
- Outputs are combinational decodes of state and inputs. Defaults: all 0 except A_S_op_o = 1.
- IDLE: rst_int = 1. Go to LOAD_OPER if beg_fsm.
- LOAD_OPER: load_1 = 1. Clear pass counter and norm_err. Go to ZERO_CHK.
- ZERO_CHK:
  - zero_flag_i → DONE.
  - Otherwise load_2 = 1 → LOAD_EXP.
- LOAD_EXP: load_3 = 1. Load wait counter with SHIFT_WAIT. Go to WAIT_A if SHIFT_WAIT > 0, else NORM_SHIFT.
- Direction rule (dir):
  - norm_iteration_i = 1 and add_overflow_i = 1 and real_op_i = 0: left_right = 0, bit_shift = 1.
  - norm_iteration_i = 1, any other case: left_right = 1, bit_shift = 0.
  - norm_iteration_i = 0: both 0.
- WAIT_A: drive dir and decrement the wait counter. Go to NORM_SHIFT when the counter reaches 1 (stays SHIFT_WAIT cycles total).
- NORM_SHIFT: load_4 = 1 and drive dir. Next state:
  - norm_iteration_i = 1 → ROUND_CHK.
  - pass count == MAX_NORM → DONE and set norm_err.
  - Otherwise → ADD_SUBT.
- ADD_SUBT: load_5 = 1, ctrl_c = 1. Go to OVF_CHK.
- OVF_CHK: load_5 = load_6 = ctrl_b_load = 1. ctrl_b = 2'b10 if (!real_op_i && add_overflow_i), else 2'b01. Go to LOAD_EXP_OVF.
- LOAD_EXP_OVF: load_3 = load_8 = 1. A_S_op = !(!real_op_i && add_overflow_i). Increment pass counter (saturating). Reload the wait counter and go to WAIT_A or NORM_SHIFT, same rule as LOAD_EXP.
- ROUND_CHK:
  - round_i → ctrl_d = ctrl_a = 1, then ADD_SUBT_R.
  - Otherwise → LOAD_FINAL.
- ADD_SUBT_R: ctrl_b_load = 1, left_right = 0.
  - add_overflow_i = 1: A_S_op = 0, ctrl_b = 2'b10, bit_shift = 1 → LOAD_EXP_R.
  - Otherwise: ctrl_b = 2'b11, bit_shift = 0. Reload the wait counter → WAIT_R, or NORM_R if SHIFT_WAIT = 0.
- LOAD_EXP_R: load_3 = load_8 = 1. Reload the wait counter → WAIT_R or NORM_R.
- WAIT_R: left_right = 0, bit_shift = add_overflow_i. Count as in WAIT_A, then go to NORM_R.
- NORM_R: load_4 = 1, left_right = 0, bit_shift = add_overflow_i. Go to LOAD_FINAL.
- LOAD_FINAL: load_7 = 1. Go to DONE.
- DONE: ready = 1; norm_err held. Go to IDLE on rst_fsm.
- Abort: rst_fsm = 1 in any state other than IDLE or DONE forces the next state to IDLE. Abort takes priority over all other transitions. norm_err is cleared.
- Illegal or unused state encodings go to IDLE.

## Timing
- Reset (async): state IDLE, counters 0, norm_err 0. Output values during reset: rst_int = 1, A_S_op_o = 1, every other output 0.
- beg_fsm sampled at edge 0 puts the FSM in LOAD_OPER in cycle 1.
- Zero path: ready in cycle 3.
- Normal path, single add pass, no round: ready in cycle 11 + 2·SHIFT_WAIT.
- Round, no overflow: ready in cycle 13 + 3·SHIFT_WAIT.
- Round with overflow: one extra cycle over round-no-overflow (LOAD_EXP_R).
- ready remains high until rst_fsm is sampled, then drops the next cycle.
- beg_fsm is ignored outside IDLE.

## Test plan
- zero_flag_i = 1 after start, W = 32 → ready rises in cycle 3; load_2..load_8 never asserted.
- W = 64, norm_iteration_i rising after one pass, round_i = 0, no overflow → ready in cycle 13; ctrl_b = 01 in OVF_CHK; exactly 2 load_4 pulses.
- real_op_i = 0, add_overflow_i = 1 → ctrl_b = 10 in OVF_CHK, A_S_op = 0 in LOAD_EXP_OVF, shift with left_right = 0 / bit_shift = 1.
- round_i = 1 with add_overflow_i = 1, SHIFT_WAIT = 0 → sequence ADD_SUBT_R, LOAD_EXP_R, NORM_R, LOAD_FINAL; ready in cycle 14.
- norm_iteration_i held 0, MAX_NORM = 2 → 2 passes, then DONE with norm_err = 1, no load_7; norm_err clears on the next start.
- rst_fsm pulsed in ADD_SUBT → IDLE next cycle, busy = 0, rst_int = 1; a new beg_fsm then completes normally.

Source files
------------

// File: rtl/fsm_add_subt_param.sv
// Control FSM for the floating-point add/subtract datapath: sequences operand load,
// alignment, add/subtract passes, rounding and final load, with shifter settle delay and watchdog.
module fsm_add_subt_param #(
  parameter int W          = 32,
  parameter int SHIFT_WAIT = (W == 64) ? 1 : 0,
  parameter int MAX_NORM   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       beg_fsm,
  input  logic       rst_fsm,
  input  logic       zero_flag_i,
  input  logic       real_op_i,
  input  logic       norm_iteration_i,
  input  logic       add_overflow_i,
  input  logic       round_i,
  output logic       load_1_o,
  output logic       load_2_o,
  output logic       load_3_o,
  output logic       load_4_o,
  output logic       load_5_o,
  output logic       load_6_o,
  output logic       load_7_o,
  output logic       load_8_o,
  output logic       A_S_op_o,
  output logic       left_right_o,
  output logic       bit_shift_o,
  output logic       ctrl_a_o,
  output logic [1:0] ctrl_b_o,
  output logic       ctrl_b_load_o,
  output logic       ctrl_c_o,
  output logic       ctrl_d_o,
  output logic       rst_int,
  output logic       ready,
  output logic       busy,
  output logic       norm_err
);

  typedef enum logic [3:0] {
    IDLE, LOAD_OPER, ZERO_CHK, LOAD_EXP, WAIT_A, NORM_SHIFT, ADD_SUBT, OVF_CHK,
    LOAD_EXP_OVF, ROUND_CHK, ADD_SUBT_R, LOAD_EXP_R, WAIT_R, NORM_R, LOAD_FINAL, DONE
  } state_t;

  localparam logic [2:0] SW = 3'(SHIFT_WAIT);
  localparam logic [2:0] MN = 3'(MAX_NORM);

  state_t     state, state_nxt;
  logic [2:0] wait_cnt, wait_nxt;
  logic [2:0] pass_cnt, pass_nxt;
  logic       err_nxt;

  // Effective subtraction that overflowed: exponent is decremented and a 1 is shifted in from the left.
  logic sub_ovf;
  logic dir_lr, dir_bs;
  assign sub_ovf = !real_op_i && add_overflow_i;
  assign dir_lr  = norm_iteration_i && !sub_ovf;
  assign dir_bs  = norm_iteration_i && sub_ovf;

  assign busy = (state != IDLE) && (state != DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      pass_cnt <= 3'd0;
      norm_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      pass_cnt <= pass_nxt;
      norm_err <= err_nxt;
    end
  end

  // NOTE: every signal written below gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    pass_nxt      = pass_cnt;
    err_nxt       = norm_err;
    load_1_o      = 1'b0;
    load_2_o      = 1'b0;
    load_3_o      = 1'b0;
    load_4_o      = 1'b0;
    load_5_o      = 1'b0;
    load_6_o      = 1'b0;
    load_7_o      = 1'b0;
    load_8_o      = 1'b0;
    A_S_op_o      = 1'b1;
    left_right_o  = 1'b0;
    bit_shift_o   = 1'b0;
    ctrl_a_o      = 1'b0;
    ctrl_b_o      = 2'b00;
    ctrl_b_load_o = 1'b0;
    ctrl_c_o      = 1'b0;
    ctrl_d_o      = 1'b0;
    rst_int       = 1'b0;
    ready         = 1'b0;

    case (state)
      IDLE: begin
        rst_int = 1'b1;
        if (beg_fsm) state_nxt = LOAD_OPER;
      end
      LOAD_OPER: begin
        load_1_o  = 1'b1;
        pass_nxt  = 3'd0;
        err_nxt   = 1'b0;
        state_nxt = ZERO_CHK;
      end
      ZERO_CHK: begin
        if (zero_flag_i) begin
          state_nxt = DONE;
        end else begin
          load_2_o  = 1'b1;
          state_nxt = LOAD_EXP;
        end
      end
      LOAD_EXP: begin
        load_3_o  = 1'b1;
        wait_nxt  = SW;
        state_nxt = (SW != 3'd0) ? WAIT_A : NORM_SHIFT;
      end
      WAIT_A: begin
        left_right_o = dir_lr;
        bit_shift_o  = dir_bs;
        wait_nxt     = wait_cnt - 3'd1;
        if (wait_cnt <= 3'd1) state_nxt = NORM_SHIFT;
      end
      NORM_SHIFT: begin
        load_4_o     = 1'b1;
        left_right_o = dir_lr;
        bit_shift_o  = dir_bs;
        if (norm_iteration_i) begin
          state_nxt = ROUND_CHK;
        end else if (pass_cnt == MN) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = ADD_SUBT;
        end
      end
      ADD_SUBT: begin
        load_5_o  = 1'b1;
        ctrl_c_o  = 1'b1;
        state_nxt = OVF_CHK;
      end
      OVF_CHK: begin
        load_5_o      = 1'b1;
        load_6_o      = 1'b1;
        ctrl_b_load_o = 1'b1;
        ctrl_b_o      = sub_ovf ? 2'b10 : 2'b01;
        state_nxt     = LOAD_EXP_OVF;
      end
      LOAD_EXP_OVF: begin
        load_3_o  = 1'b1;
        load_8_o  = 1'b1;
        A_S_op_o  = !sub_ovf;
        if (pass_cnt != 3'd7) pass_nxt = pass_cnt + 3'd1;
        wait_nxt  = SW;
        state_nxt = (SW != 3'd0) ? WAIT_A : NORM_SHIFT;
      end
      ROUND_CHK: begin
        if (round_i) begin
          ctrl_d_o  = 1'b1;
          ctrl_a_o  = 1'b1;
          state_nxt = ADD_SUBT_R;
        end else begin
          state_nxt = LOAD_FINAL;
        end
      end
      ADD_SUBT_R: begin
        ctrl_b_load_o = 1'b1;
        if (add_overflow_i) begin
          A_S_op_o    = 1'b0;
          ctrl_b_o    = 2'b10;
          bit_shift_o = 1'b1;
          state_nxt   = LOAD_EXP_R;
        end else begin
          ctrl_b_o  = 2'b11;
          wait_nxt  = SW;
          state_nxt = (SW != 3'd0) ? WAIT_R : NORM_R;
        end
      end
      LOAD_EXP_R: begin
        load_3_o  = 1'b1;
        load_8_o  = 1'b1;
        wait_nxt  = SW;
        state_nxt = (SW != 3'd0) ? WAIT_R : NORM_R;
      end
      WAIT_R: begin
        bit_shift_o = add_overflow_i;
        wait_nxt    = wait_cnt - 3'd1;
        if (wait_cnt <= 3'd1) state_nxt = NORM_R;
      end
      NORM_R: begin
        load_4_o    = 1'b1;
        bit_shift_o = add_overflow_i;
        state_nxt   = LOAD_FINAL;
      end
      LOAD_FINAL: begin
        load_7_o  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        ready = 1'b1;
        if (rst_fsm) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Abort overrides every other transition while an operation is in flight.
    if (rst_fsm && (state != IDLE) && (state != DONE)) begin
      state_nxt = IDLE;
      err_nxt   = 1'b0;
    end
  end

endmodule

// File: tb/tb_fsm_add_subt_param.sv
// Scoreboard bench for fsm_add_subt_param: random operations are issued with their predicted
// latency and pulse counts; a monitor compares them when ready rises.
module tb_fsm_add_subt_param;
  localparam int W    = 64;
  localparam int SW   = 1;   // SHIFT_WAIT default for W = 64
  localparam int MN   = 2;
  localparam int NTXN = 50;

  logic clk = 1'b0, rst = 1'b1;
  logic beg_fsm = 1'b0, rst_fsm = 1'b0;
  logic zero_flag_i = 1'b0, real_op_i = 1'b0, norm_iteration_i = 1'b0;
  logic add_overflow_i = 1'b0, round_i = 1'b0;
  logic load_1_o, load_2_o, load_3_o, load_4_o, load_5_o, load_6_o, load_7_o, load_8_o;
  logic A_S_op_o, left_right_o, bit_shift_o, ctrl_a_o, ctrl_b_load_o, ctrl_c_o, ctrl_d_o;
  logic [1:0] ctrl_b_o;
  logic rst_int, ready, busy, norm_err;

  fsm_add_subt_param #(.W(W), .MAX_NORM(MN)) dut (
    .clk(clk), .rst(rst), .beg_fsm(beg_fsm), .rst_fsm(rst_fsm),
    .zero_flag_i(zero_flag_i), .real_op_i(real_op_i), .norm_iteration_i(norm_iteration_i),
    .add_overflow_i(add_overflow_i), .round_i(round_i),
    .load_1_o(load_1_o), .load_2_o(load_2_o), .load_3_o(load_3_o), .load_4_o(load_4_o),
    .load_5_o(load_5_o), .load_6_o(load_6_o), .load_7_o(load_7_o), .load_8_o(load_8_o),
    .A_S_op_o(A_S_op_o), .left_right_o(left_right_o), .bit_shift_o(bit_shift_o),
    .ctrl_a_o(ctrl_a_o), .ctrl_b_o(ctrl_b_o), .ctrl_b_load_o(ctrl_b_load_o),
    .ctrl_c_o(ctrl_c_o), .ctrl_d_o(ctrl_d_o), .rst_int(rst_int), .ready(ready),
    .busy(busy), .norm_err(norm_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int start, hold, lat, err;
    int n2, n3, n4, n5, n6, n7, n8;
    int cb, as_op, dirn, dirr, cbr, asr;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: closed-form latency and pulse counts from the operation's
  // rules. One alignment pass costs ADD_SUBT, OVF_CHK, LOAD_EXP_OVF, SW waits and a shift.
  function automatic exp_t model(input bit zero, input bit real_op, input bit ovf,
                                 input bit rnd, input int k);
    exp_t e;
    int   p, t;
    bit   so, rd;
    e = '{default: 0};
    e.as_op = 1; e.dirn = 3; e.dirr = 3; e.asr = 1;
    if (zero) begin
      e.lat = 3;
      return e;
    end
    e.err = (k > MN) ? 1 : 0;
    p  = e.err ? MN : k;
    so = !real_op && ovf;
    rd = !e.err && rnd;
    t  = 4 + SW;
    if (e.err)   e.lat = (p + 1) * t + 1;
    else if (rd) e.lat = (p + 1) * t + 1 + 4 + SW + int'(ovf);
    else         e.lat = (p + 1) * t + 3;
    e.n2 = 1;
    e.n3 = 1 + p + int'(rd && ovf);
    e.n4 = p + 1 + int'(rd);
    e.n5 = 2 * p;
    e.n6 = p;
    e.n7 = e.err ? 0 : 1;
    e.n8 = p + int'(rd && ovf);
    e.cb    = (p > 0) ? (so ? 2 : 1) : 0;
    e.as_op = (p > 0) ? int'(!so) : 1;
    e.dirn  = e.err ? 0 : (so ? 1 : 2);
    e.dirr  = rd ? int'(ovf) : 3;
    e.cbr   = rd ? (ovf ? 2 : 3) : 0;
    e.asr   = rd ? int'(!ovf) : 1;
    return e;
  endfunction

  // Monitor: observes DUT outputs on the falling edge, compares on ready.
  bit   active = 0, in_done = 0, after_r = 0;
  int   rdy_cnt, busy_cnt, rint_cnt;
  int   c2, c3, c4, c5, c6, c7, c8;
  int   o_cb, o_as, o_dirn, o_dirr, o_cbr, o_asr;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst) begin
      if (ready && !in_done) begin
        in_done = 1; rdy_cnt = 1; active = 0;
        check("sb_has_item", longint'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          check("latency", cyc - cur.start, cur.lat);
          check("norm_err", int'(norm_err), cur.err);
          check("busy_in_done", int'(busy), 0);
          check("busy_cycles", busy_cnt, cur.lat - 1);
          check("rst_int_cycles", rint_cnt, 0);
          check("load_2_cnt", c2, cur.n2);
          check("load_3_cnt", c3, cur.n3);
          check("load_4_cnt", c4, cur.n4);
          check("load_5_cnt", c5, cur.n5);
          check("load_6_cnt", c6, cur.n6);
          check("load_7_cnt", c7, cur.n7);
          check("load_8_cnt", c8, cur.n8);
          check("ctrl_b_ovf_chk", o_cb, cur.cb);
          check("a_s_op_exp_ovf", o_as, cur.as_op);
          check("dir_norm_shift", o_dirn, cur.dirn);
          check("dir_norm_r", o_dirr, cur.dirr);
          check("ctrl_b_round", o_cbr, cur.cbr);
          check("a_s_op_round", o_asr, cur.asr);
        end
      end else if (ready && in_done) begin
        rdy_cnt++;
      end else if (!ready && in_done) begin
        in_done = 0;
        check("ready_hold", rdy_cnt, cur.hold + 1);
      end
      if (load_1_o) begin
        active = 1; after_r = 0;
        busy_cnt = 0; rint_cnt = 0;
        c2 = 0; c3 = 0; c4 = 0; c5 = 0; c6 = 0; c7 = 0; c8 = 0;
        o_cb = 0; o_as = 1; o_dirn = 3; o_dirr = 3; o_cbr = 0; o_asr = 1;
      end
      if (active) begin
        busy_cnt += int'(busy);
        rint_cnt += int'(rst_int);
        c2 += int'(load_2_o); c3 += int'(load_3_o); c4 += int'(load_4_o);
        c5 += int'(load_5_o); c6 += int'(load_6_o); c7 += int'(load_7_o);
        c8 += int'(load_8_o);
        if (ctrl_d_o) after_r = 1;
        if (load_6_o) o_cb = int'(ctrl_b_o);
        if (load_8_o && !after_r) o_as = int'(A_S_op_o);
        if (load_4_o && !after_r) o_dirn = int'({left_right_o, bit_shift_o});
        if (load_4_o && after_r) o_dirr = int'({left_right_o, bit_shift_o});
        if (ctrl_b_load_o && !load_6_o) begin
          o_cbr = int'(ctrl_b_o);
          o_asr = int'(A_S_op_o);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: plays the datapath, raising norm_iteration_i once k passes have completed.
  task automatic run_txn(input bit zero, input bit real_op, input bit ovf, input bit rnd,
                         input int k, input int hold);
    exp_t e;
    int   seen;
    bit   got;
    e       = model(zero, real_op, ovf, rnd, k);
    e.start = cyc;
    e.hold  = hold;
    zero_flag_i      = zero;
    real_op_i        = real_op;
    add_overflow_i   = ovf;
    round_i          = rnd;
    norm_iteration_i = (k == 0);
    beg_fsm          = 1'b1;
    sb.push_back(e);
    seen = 0;
    got  = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      if (load_8_o) seen++;
      norm_iteration_i = (seen >= k);
      if (ready) begin
        got     = 1;
        beg_fsm = 1'b0;
      end else begin
        beg_fsm = 1'($urandom_range(0, 1));
      end
    end
    check("ready_seen", longint'(got), 1);
    if (!got) begin
      beg_fsm = 1'b0;
      e = sb.pop_back();
    end
    repeat (hold) step();
    rst_fsm = 1'b1;
    step();
    rst_fsm = 1'b0;
  endtask

  task automatic run_abort();
    bit hit;
    hit = 0;
    zero_flag_i = 1'b0; real_op_i = 1'b1; add_overflow_i = 1'b0;
    round_i = 1'b0; norm_iteration_i = 1'b0;
    beg_fsm = 1'b1;
    for (int i = 0; i < 50 && !hit; i++) begin
      step();
      beg_fsm = 1'b0;
      if (ctrl_c_o) hit = 1;
    end
    check("abort_reached_add_subt", longint'(hit), 1);
    rst_fsm = 1'b1;
    step();
    rst_fsm = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_rst_int", int'(rst_int), 1);
    check("abort_ready", int'(ready), 0);
    check("abort_norm_err", int'(norm_err), 0);
    step();
    check("abort_stays_idle", int'(busy), 0);
  endtask

  initial begin
    #12;
    check("reset_rst_int", int'(rst_int), 1);
    check("reset_a_s_op", int'(A_S_op_o), 1);
    check("reset_others", int'(|{load_1_o, load_2_o, load_3_o, load_4_o, load_5_o, load_6_o,
                                  load_7_o, load_8_o, left_right_o, bit_shift_o, ctrl_a_o,
                                  ctrl_b_o, ctrl_b_load_o, ctrl_c_o, ctrl_d_o, ready, busy,
                                  norm_err}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Directed cases: zero, plain pass, subtract overflow, round with overflow,
    // watchdog, then a clean operation that must clear norm_err.
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
    run_txn(1'b0, 1'b1, 1'b1, 1'b1, 1, 2);
    run_txn(1'b0, 1'b1, 1'b0, 1'b1, 1, 0);
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 3, 1);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    run_abort();
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 2, 0);

    for (int n = 0; n < NTXN; n++) begin
      run_txn(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (5) step();
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
